// File: rtl/ghost_map_updater.sv
// ---------------------------------------------------------------------------
// ghost_map_updater
//
// Moves both ghosts on the shared board-map RAM. One accepted start runs a
// fixed eight-state sequence: restore the tile under ghost1, restore the tile
// under ghost2, read/decide/draw ghost1, read/decide/draw ghost2, then pulse
// wrdone so the upstream location controller can commit next -> curr.
// Both restores happen before any read, so a ghost moving onto the other
// ghost's old tile (or not moving at all) always reads the true map content.
//
// Ports
//   CLOCK_50                      system clock
//   reset                         synchronous, active-high reset
//   start                         one-cycle request, sampled only in IDLE
//   curr_ghost{1,2}_{x,y}         current ghost tiles (latched on start)
//   next_ghost{1,2}_{x,y}         requested ghost tiles (latched on start)
//   rd_x, rd_y                    map read address (registered)
//   rddata                        map tile code, valid the cycle after rd_*
//   wr_en, wr_x, wr_y, wr_data    map write port (combinational from state)
//   busy                          high from CLR1 through DONE
//   wrdone                        one-cycle completion pulse
//   ghost_hit                     bit k-1: ghost k landed on pacman
//   blocked                       bit k-1: ghost k move refused
// ---------------------------------------------------------------------------
module ghost_map_updater #(
  parameter int MAP_W = 40,
  parameter int MAP_H = 30
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] curr_ghost1_x,
  input  logic [4:0] curr_ghost1_y,
  input  logic [5:0] curr_ghost2_x,
  input  logic [4:0] curr_ghost2_y,
  input  logic [5:0] next_ghost1_x,
  input  logic [4:0] next_ghost1_y,
  input  logic [5:0] next_ghost2_x,
  input  logic [4:0] next_ghost2_y,
  output logic [5:0] rd_x,
  output logic [4:0] rd_y,
  input  logic [2:0] rddata,
  output logic       wr_en,
  output logic [5:0] wr_x,
  output logic [4:0] wr_y,
  output logic [2:0] wr_data,
  output logic       busy,
  output logic       wrdone,
  output logic [1:0] ghost_hit,
  output logic [1:0] blocked
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR1 = 3'd1,
    S_CLR2 = 3'd2,
    S_RD1  = 3'd3,
    S_CAP1 = 3'd4,
    S_RD2  = 3'd5,
    S_CAP2 = 3'd6,
    S_DONE = 3'd7
  } state_t;

  localparam logic [2:0] T_EMPTY  = 3'd0;
  localparam logic [2:0] T_WALL   = 3'd1;
  localparam logic [2:0] T_PACMAN = 3'd4;
  localparam logic [2:0] T_GHOST1 = 3'd5;
  localparam logic [2:0] T_GHOST2 = 3'd6;
  localparam logic [2:0] T_RSVD   = 3'd7;

  // One extra bit so a 6-bit x can be compared against MAP_W up to 64.
  localparam logic [6:0] MAP_W_L = 7'(MAP_W);
  localparam logic [5:0] MAP_H_L = 6'(MAP_H);

  state_t     state_q;
  logic [5:0] c1x_q, c2x_q, n1x_q, n2x_q;
  logic [4:0] c1y_q, c2y_q, n1y_q, n2y_q;
  logic [2:0] under1_q, under2_q;
  logic [5:0] rd_x_q;
  logic [4:0] rd_y_q;
  logic [1:0] ghost_hit_q, blocked_q;
  logic       busy_q, wrdone_q;

  // Per-ghost view selected by which CAP state is active.
  logic [5:0] sel_cx_s, sel_nx_s;
  logic [4:0] sel_cy_s, sel_ny_s;
  logic [2:0] sel_under_s;
  logic       off_board_s, stack_s;

  // Outcome of the CAP decision.
  logic       cap_blk_s, cap_hit_s;
  logic [5:0] cap_x_s;
  logic [4:0] cap_y_s;
  logic [2:0] cap_under_d;

  logic       wr_en_s;
  logic [5:0] wr_x_s;
  logic [4:0] wr_y_s;
  logic [2:0] wr_data_s;

  // CAP decision: where the ghost is drawn and what it now covers.
  always_comb begin
    sel_cx_s    = c1x_q;
    sel_cy_s    = c1y_q;
    sel_nx_s    = n1x_q;
    sel_ny_s    = n1y_q;
    sel_under_s = under1_q;
    if (state_q == S_CAP2) begin
      sel_cx_s    = c2x_q;
      sel_cy_s    = c2y_q;
      sel_nx_s    = n2x_q;
      sel_ny_s    = n2y_q;
      sel_under_s = under2_q;
    end else begin
      sel_cx_s    = c1x_q;
      sel_cy_s    = c1y_q;
      sel_nx_s    = n1x_q;
      sel_ny_s    = n1y_q;
      sel_under_s = under1_q;
    end

    off_board_s = ({1'b0, sel_nx_s} >= MAP_W_L) || ({1'b0, sel_ny_s} >= MAP_H_L);
    // Ghost2 stacking on ghost1 inherits ghost1's underlying tile so that
    // neither ghost code is ever restored into the map later.
    stack_s     = (state_q == S_CAP2) && (rddata == T_GHOST1) &&
                  ({n2x_q, n2y_q} == {n1x_q, n1y_q});

    cap_blk_s   = 1'b0;
    cap_hit_s   = 1'b0;
    cap_x_s     = sel_nx_s;
    cap_y_s     = sel_ny_s;
    cap_under_d = rddata;
    if (off_board_s || (rddata == T_WALL) || (rddata == T_RSVD)) begin
      // Refused move: redraw in place, keep the old underlying tile.
      cap_blk_s   = 1'b1;
      cap_x_s     = sel_cx_s;
      cap_y_s     = sel_cy_s;
      cap_under_d = sel_under_s;
    end else if (rddata == T_PACMAN) begin
      cap_hit_s   = 1'b1;
      cap_under_d = T_EMPTY;
    end else if (stack_s) begin
      cap_under_d = under1_q;
    end else begin
      cap_under_d = rddata;
    end
  end

  // Map write port; suppressed while reset is asserted so an interrupted
  // operation performs no further writes.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_x_s    = 6'd0;
    wr_y_s    = 5'd0;
    wr_data_s = 3'd0;
    if (reset) begin
      wr_en_s   = 1'b0;
      wr_x_s    = 6'd0;
      wr_y_s    = 5'd0;
      wr_data_s = 3'd0;
    end else begin
      case (state_q)
        S_CLR1: begin
          wr_en_s   = 1'b1;
          wr_x_s    = c1x_q;
          wr_y_s    = c1y_q;
          wr_data_s = under1_q;
        end
        S_CLR2: begin
          wr_en_s   = 1'b1;
          wr_x_s    = c2x_q;
          wr_y_s    = c2y_q;
          wr_data_s = under2_q;
        end
        S_CAP1: begin
          wr_en_s   = 1'b1;
          wr_x_s    = cap_x_s;
          wr_y_s    = cap_y_s;
          wr_data_s = T_GHOST1;
        end
        S_CAP2: begin
          wr_en_s   = 1'b1;
          wr_x_s    = cap_x_s;
          wr_y_s    = cap_y_s;
          wr_data_s = T_GHOST2;
        end
        default: begin
          wr_en_s   = 1'b0;
          wr_x_s    = 6'd0;
          wr_y_s    = 5'd0;
          wr_data_s = 3'd0;
        end
      endcase
    end
  end

  // Sequencer: state, captured positions, underlying tiles, status flags.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      c1x_q       <= 6'd16;
      c1y_q       <= 5'd13;
      n1x_q       <= 6'd16;
      n1y_q       <= 5'd13;
      c2x_q       <= 6'd23;
      c2y_q       <= 5'd13;
      n2x_q       <= 6'd23;
      n2y_q       <= 5'd13;
      under1_q    <= T_EMPTY;
      under2_q    <= T_EMPTY;
      rd_x_q      <= 6'd0;
      rd_y_q      <= 5'd0;
      ghost_hit_q <= 2'b00;
      blocked_q   <= 2'b00;
      busy_q      <= 1'b0;
      wrdone_q    <= 1'b0;
    end else begin
      wrdone_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            c1x_q       <= curr_ghost1_x;
            c1y_q       <= curr_ghost1_y;
            c2x_q       <= curr_ghost2_x;
            c2y_q       <= curr_ghost2_y;
            n1x_q       <= next_ghost1_x;
            n1y_q       <= next_ghost1_y;
            n2x_q       <= next_ghost2_x;
            n2y_q       <= next_ghost2_y;
            ghost_hit_q <= 2'b00;
            blocked_q   <= 2'b00;
            busy_q      <= 1'b1;
            state_q     <= S_CLR1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLR1: state_q <= S_CLR2;
        S_CLR2: begin
          rd_x_q  <= n1x_q;
          rd_y_q  <= n1y_q;
          state_q <= S_RD1;
        end
        S_RD1: state_q <= S_CAP1;
        S_CAP1: begin
          under1_q <= cap_under_d;
          if (cap_blk_s) blocked_q[0]   <= 1'b1;
          if (cap_hit_s) ghost_hit_q[0] <= 1'b1;
          rd_x_q   <= n2x_q;
          rd_y_q   <= n2y_q;
          state_q  <= S_RD2;
        end
        S_RD2: state_q <= S_CAP2;
        S_CAP2: begin
          under2_q <= cap_under_d;
          if (cap_blk_s) blocked_q[1]   <= 1'b1;
          if (cap_hit_s) ghost_hit_q[1] <= 1'b1;
          wrdone_q <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_x      = rd_x_q;
  assign rd_y      = rd_y_q;
  assign wr_en     = wr_en_s;
  assign wr_x      = wr_x_s;
  assign wr_y      = wr_y_s;
  assign wr_data   = wr_data_s;
  assign busy      = busy_q;
  assign wrdone    = wrdone_q;
  assign ghost_hit = ghost_hit_q;
  assign blocked   = blocked_q;

endmodule

// File: tb/tb_ghost_map_updater.sv
// Bench for ghost_map_updater: a behavioural registered map RAM, directed
// move vectors with hand-computed writes, and a scoreboard monitor that pops
// expected writes / completions / level checks as the DUT presents them.
module tb_ghost_map_updater;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] curr_ghost1_x = 6'd0, curr_ghost2_x = 6'd0, next_ghost1_x = 6'd0, next_ghost2_x = 6'd0;
  logic [4:0] curr_ghost1_y = 5'd0, curr_ghost2_y = 5'd0, next_ghost1_y = 5'd0, next_ghost2_y = 5'd0;
  logic [5:0] rd_x, wr_x;
  logic [4:0] rd_y, wr_y;
  logic [2:0] rddata = 3'd0;
  logic       wr_en, busy, wrdone;
  logic [2:0] wr_data;
  logic [1:0] ghost_hit, blocked;

  ghost_map_updater dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .curr_ghost1_x(curr_ghost1_x), .curr_ghost1_y(curr_ghost1_y),
    .curr_ghost2_x(curr_ghost2_x), .curr_ghost2_y(curr_ghost2_y),
    .next_ghost1_x(next_ghost1_x), .next_ghost1_y(next_ghost1_y),
    .next_ghost2_x(next_ghost2_x), .next_ghost2_y(next_ghost2_y),
    .rd_x(rd_x), .rd_y(rd_y), .rddata(rddata),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .busy(busy), .wrdone(wrdone), .ghost_hit(ghost_hit), .blocked(blocked)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Registered map RAM with a bench-side clear/poke port.
  logic [2:0] mem [0:63][0:31];
  logic       clr_req = 1'b0, poke_en = 1'b0;
  logic [5:0] poke_x = 6'd0;
  logic [4:0] poke_y = 5'd0;
  logic [2:0] poke_d = 3'd0;
  always @(posedge CLOCK_50) begin
    if (clr_req) begin
      for (int x = 0; x < 64; x++)
        for (int y = 0; y < 32; y++)
          mem[x][y] <= 3'd0;
    end else if (poke_en) begin
      mem[poke_x][poke_y] <= poke_d;
    end
    if (wr_en) mem[wr_x][wr_y] <= wr_data;
    rddata <= mem[rd_x][rd_y];
  end

  localparam int K_BUSY = 0, K_FLAGS = 1, K_WRDONE = 2, K_RST = 3, K_MAP = 4;
  typedef struct { int cyc; logic [13:0] w; } wr_e_t;
  typedef struct { int cyc; logic [3:0] f; } dn_e_t;
  typedef struct { int cyc; int kind; logic [31:0] e; logic [5:0] x; logic [4:0] y; } lv_e_t;
  wr_e_t wq[$];
  dn_e_t dq[$];
  lv_e_t lq[$];

  int n_tests = 0;
  int n_fail  = 0;
  logic stim_done = 1'b0;

  function automatic logic [10:0] P(input int x, input int y);
    return {6'(x), 5'(y)};
  endfunction
  function automatic logic [13:0] W(input int x, input int y, input int d);
    return {6'(x), 5'(y), 3'(d)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", nm, cyc, a, e);
    end
  endtask

  function automatic lv_e_t LV(input int c, input int k, input logic [31:0] e);
    lv_e_t l;
    l.cyc = c; l.kind = k; l.e = e; l.x = 6'd0; l.y = 5'd0;
    return l;
  endfunction

  // Monitor / scoreboard: sole owner of the pass/fail counters.
  initial begin : monitor
    wr_e_t we;
    dn_e_t de;
    lv_e_t le;
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if (wr_en) begin
          if (wq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_write @cyc %0d: got (%0d,%0d)<-%0d expected none", cyc, wr_x, wr_y, wr_data);
          end else begin
            we = wq.pop_front();
            chk("write {cyc,x,y,d}", {2'b0, 16'(cyc), wr_x, wr_y, wr_data}, {2'b0, 16'(we.cyc), we.w});
          end
        end
        if (wrdone) begin
          if (dq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_wrdone @cyc %0d: got 1 expected 0", cyc);
          end else begin
            de = dq.pop_front();
            chk("wrdone_cycle", 32'(cyc), 32'(de.cyc));
            chk("done_flags {hit,blocked}", {28'b0, ghost_hit, blocked}, {28'b0, de.f});
          end
        end
        while (lq.size() > 0 && lq[0].cyc <= cyc) begin
          le = lq.pop_front();
          case (le.kind)
            K_BUSY:   chk("busy", {31'b0, busy}, le.e);
            K_FLAGS:  chk("flags {hit,blocked}", {28'b0, ghost_hit, blocked}, le.e);
            K_WRDONE: chk("wrdone_level", {31'b0, wrdone}, le.e);
            K_RST:    chk("reset_state", {busy, wr_en, wrdone, ghost_hit, blocked, rd_x, rd_y, wr_x, wr_y, wr_data}, le.e);
            K_MAP:    chk("map_tile", {29'b0, mem[le.x][le.y]}, le.e);
            default:  chk("bad_kind", 32'(le.kind), 32'hFFFF_FFFF);
          endcase
        end
      end
      if (stim_done) begin
        chk("queues_drained", 32'(wq.size() + dq.size() + lq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge CLOCK_50); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clr_req = 1'b1; start = 1'b0;
    step(); step();
    reset = 1'b0; clr_req = 1'b0;
    lq.push_back(LV(cyc, K_RST, 32'd0));
    step();
  endtask

  task automatic poke(input int x, input int y, input int d);
    poke_x = 6'(x); poke_y = 5'(y); poke_d = 3'(d); poke_en = 1'b1;
    step();
    poke_en = 1'b0;
  endtask

  task automatic chk_map(input int x, input int y, input int d);
    lv_e_t l;
    l = LV(cyc, K_MAP, 32'(d));
    l.x = 6'(x); l.y = 5'(y);
    lq.push_back(l);
    step();
  endtask

  // mode 0: plain; 1: ignored starts in cycles 3 and 5; 2: reset during CAP1.
  // Writes expected at cycles 1,2,4,6 (only 1,2 in mode 2). Returns at cycle 8.
  task automatic do_op(input logic [10:0] c1, input logic [10:0] c2,
                       input logic [10:0] n1, input logic [10:0] n2,
                       input logic [55:0] ew, input logic [3:0] ef, input int mode);
    int base;
    int wc [4];
    wr_e_t we;
    dn_e_t de;
    wc[0] = 1; wc[1] = 2; wc[2] = 4; wc[3] = 6;
    {curr_ghost1_x, curr_ghost1_y} = c1;
    {curr_ghost2_x, curr_ghost2_y} = c2;
    {next_ghost1_x, next_ghost1_y} = n1;
    {next_ghost2_x, next_ghost2_y} = n2;
    start = 1'b1;
    base = cyc;
    for (int i = 0; i < ((mode == 2) ? 2 : 4); i++) begin
      we.cyc = base + wc[i];
      we.w   = ew[55 - 14*i -: 14];
      wq.push_back(we);
    end
    lq.push_back(LV(base + 1, K_FLAGS, 32'd0));
    lq.push_back(LV(base + 1, K_BUSY, 32'd1));
    if (mode == 2) begin
      lq.push_back(LV(base + 5, K_RST, 32'd0));
      lq.push_back(LV(base + 7, K_WRDONE, 32'd0));
    end else begin
      de.cyc = base + 7; de.f = ef;
      dq.push_back(de);
      lq.push_back(LV(base + 7, K_BUSY, 32'd1));
      lq.push_back(LV(base + 8, K_BUSY, 32'd0));
      lq.push_back(LV(base + 8, K_FLAGS, {28'b0, ef}));
    end
    step();
    start = 1'b0;
    // Scramble inputs: the latched copies must be the only ones used.
    {curr_ghost1_x, curr_ghost1_y} = P(5, 5);
    {curr_ghost2_x, curr_ghost2_y} = P(6, 6);
    {next_ghost1_x, next_ghost1_y} = P(7, 7);
    {next_ghost2_x, next_ghost2_y} = P(8, 8);
    for (int k = 1; k <= 7; k++) begin
      start = (mode == 1) && (k == 3 || k == 5);
      reset = (mode == 2) && (k == 4);
      step();
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin : stimulus
    do_reset();

    // Basic move, then back-to-back second move restoring the pill.
    poke(16, 12, 2);
    do_op(P(16,13), P(23,13), P(16,12), P(24,13),
          {W(16,13,0), W(23,13,0), W(16,12,5), W(24,13,6)}, 4'b0000, 0);
    do_op(P(16,12), P(24,13), P(16,11), P(24,13),
          {W(16,12,2), W(24,13,0), W(16,11,5), W(24,13,6)}, 4'b0000, 0);

    // Wall, off-board x, reserved code + off-board y, last on-board tile.
    do_reset();
    poke(16, 12, 1);
    do_op(P(16,13), P(23,13), P(16,12), P(23,13),
          {W(16,13,0), W(23,13,0), W(16,13,5), W(23,13,6)}, 4'b0001, 0);
    do_op(P(16,13), P(23,13), P(15,13), P(40,13),
          {W(16,13,0), W(23,13,0), W(15,13,5), W(23,13,6)}, 4'b0010, 0);
    poke(14, 13, 7);
    do_op(P(15,13), P(23,13), P(14,13), P(23,30),
          {W(15,13,0), W(23,13,0), W(15,13,5), W(23,13,6)}, 4'b0011, 0);
    do_op(P(15,13), P(23,13), P(15,13), P(39,29),
          {W(15,13,0), W(23,13,0), W(15,13,5), W(39,29,6)}, 4'b0000, 0);

    // Pacman hit by ghost2; flags clear and pacman is not restored.
    do_reset();
    poke(24, 13, 4);
    do_op(P(16,13), P(23,13), P(16,13), P(24,13),
          {W(16,13,0), W(23,13,0), W(16,13,5), W(24,13,6)}, 4'b1000, 0);
    do_op(P(16,13), P(24,13), P(17,13), P(25,13),
          {W(16,13,0), W(24,13,0), W(17,13,5), W(25,13,6)}, 4'b0000, 0);

    // Stacking on a pill, then both ghosts leave: pill restored twice.
    do_reset();
    poke(20, 13, 2);
    do_op(P(16,13), P(23,13), P(20,13), P(20,13),
          {W(16,13,0), W(23,13,0), W(20,13,5), W(20,13,6)}, 4'b0000, 0);
    do_op(P(20,13), P(20,13), P(21,13), P(19,13),
          {W(20,13,2), W(20,13,2), W(21,13,5), W(19,13,6)}, 4'b0000, 0);
    chk_map(20, 13, 2);

    // Swap: each ghost moves onto the other's tile.
    do_reset();
    poke(17, 13, 2);
    poke(22, 13, 3);
    do_op(P(16,13), P(23,13), P(17,13), P(22,13),
          {W(16,13,0), W(23,13,0), W(17,13,5), W(22,13,6)}, 4'b0000, 0);
    do_op(P(17,13), P(22,13), P(22,13), P(17,13),
          {W(17,13,2), W(22,13,3), W(22,13,5), W(17,13,6)}, 4'b0000, 0);
    do_op(P(22,13), P(17,13), P(21,13), P(18,13),
          {W(22,13,3), W(17,13,2), W(21,13,5), W(18,13,6)}, 4'b0000, 0);
    chk_map(22, 13, 3);
    chk_map(17, 13, 2);

    // Protocol: ignored starts, then reset during CAP1, then a clean op.
    do_reset();
    do_op(P(16,13), P(23,13), P(16,12), P(23,12),
          {W(16,13,0), W(23,13,0), W(16,12,5), W(23,12,6)}, 4'b0000, 1);
    do_op(P(16,12), P(23,12), P(16,11), P(23,11),
          {W(16,12,0), W(23,12,0), W(0,0,0), W(0,0,0)}, 4'b0000, 2);
    do_op(P(16,13), P(23,13), P(16,13), P(23,13),
          {W(16,13,0), W(23,13,0), W(16,13,5), W(23,13,6)}, 4'b0000, 0);

    step(); step();
    stim_done = 1'b1;
  end

endmodule

// File: doc/ghost_map_updater.md
# ghost_map_updater

Writes ghost movement into the shared board-map RAM. Each accepted `start` erases both ghosts from their current tiles, restores the tile each ghost was covering, and reads the destination tiles. It then draws the ghosts at their new tiles and pulses `wrdone`. It sits downstream of the ghost location controller: it consumes `curr_ghost*`/`next_ghost*`, and its `wrdone` pulse commits next→curr in that controller.

## Interface
Parameters:
- `MAP_W`, default 40: board width in tiles; x ≥ MAP_W is off-board.
- `MAP_H`, default 30: board height in tiles; y ≥ MAP_H is off-board.

Ports:
- `CLOCK_50`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; clock CLOCK_50.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `curr_ghost1_x`, `curr_ghost2_x`  in  6  current tile x.
- `curr_ghost1_y`, `curr_ghost2_y`  in  5  current tile y.
- `next_ghost1_x`, `next_ghost2_x`  in  6  requested tile x.
- `next_ghost1_y`, `next_ghost2_y`  in  5  requested tile y.
- `rd_x`  out  6  map read address x.
- `rd_y`  out  5  map read address y.
- `rddata`  in  3  map tile code; registered RAM, valid the cycle after the address is presented.
- `wr_en`  out  1  map write strobe.
- `wr_x`  out  6  write address x.
- `wr_y`  out  5  write address y.
- `wr_data`  out  3  tile code to write.
- `busy`  out  1  high from CLR1 through DONE.
- `wrdone`  out  1  one-cycle pulse; update complete.
- `ghost_hit`  out  2  bit0 = ghost1 landed on pacman; bit1 = ghost2 landed on pacman.
- `blocked`  out  2  bit0 = ghost1 move refused; bit1 = ghost2 move refused.

## Operation
- Tile codes: 0 EMPTY, 1 WALL, 2 PILL, 3 POWER, 4 PACMAN, 5 GHOST1, 6 GHOST2, 7 reserved (treated as WALL).
- Internal registers:
  - `under1`, `under2`: tile code beneath each ghost.
  - `c1`, `c2`: captured current positions.
  - `n1`, `n2`: captured next positions.
- On `start` in IDLE: all eight position inputs are latched into `c1`, `c2`, `n1`, `n2`. Input changes during the operation have no effect.
- States:
  - IDLE: `start`→CLR1.
  - CLR1: `wr_en=1`, addr `c1`, data `under1`.
  - CLR2: `wr_en=1`, addr `c2`, data `under2`.
  - RD1: `rd=n1`.
  - CAP1: evaluate `rddata`; write GHOST1.
  - RD2: `rd=n2`.
  - CAP2: evaluate `rddata`; write GHOST2.
  - DONE: `wrdone=1`; →IDLE.
- CAPk decision, on `rddata` or the bounds check:
  - WALL/7, or n off-board (x ≥ MAP_W or y ≥ MAP_H; the read result is ignored): write GHOSTk at `ck`; `underk` unchanged; set `blocked[k]`.
  - PACMAN: `underk := EMPTY`; write GHOSTk at `nk`; set `ghost_hit[k]`.
  - GHOST1 (CAP2 only, n2 == n1): `under2 := under1`; write GHOST2 at `n2`, drawn on top.
  - Otherwise: `underk := rddata`; write GHOSTk at `nk`.
- Restore order (both CLRs before any read) guarantees:
  - n1 == c2 reads ghost2's true underlying tile.
  - n == c (no move) reads back the restored tile.
- `ghost_hit` and `blocked` are registered. They clear on `start` acceptance, set in CAPk, and hold until the next accepted `start`.
- `start` while `busy` is ignored, not queued.
- Reset mid-operation: FSM→IDLE immediately; no further writes. The map is not repaired.

## Timing
- Reset values:
  - IDLE.
  - `wr_en=0`, `wrdone=0`, `busy=0`, `ghost_hit=0`, `blocked=0`.
  - `rd_x=0`, `rd_y=0`, `wr_x=0`, `wr_y=0`, `wr_data=0`.
  - `under1=under2=EMPTY`.
  - `c1`/`n1`=(16,13), `c2`/`n2`=(23,13).
- Output drive:
  - `wr_en`/`wr_x`/`wr_y`/`wr_data` are combinational from state in CLR1/CLR2.
  - In CAPk they are combinational from state plus `rddata`.
  - `wr_en=0` in all other states.
- `rd_x`/`rd_y` are held at the RDk address through CAPk; otherwise they hold their last value.
- Cycle schedule, with `start` sampled at edge 0:
  - CLR1 in cycle 1, CLR2 in 2, RD1 in 3, CAP1 in 4, RD2 in 5, CAP2 in 6, DONE in 7.
  - `wrdone` is high for cycle 7 only.
  - Earliest next `start` accepted: edge 8.
- Exactly 4 map writes per operation, at cycles 1, 2, 4, 6.

## Test plan
- Basic move: reset; map (16,12)=PILL; `next1`=(16,12), `next2`=(24,13); pulse `start`. Expect:
  - writes (16,13)←0, (23,13)←0, (16,12)←5, (24,13)←6;
  - `wrdone` at cycle 7;
  - then a second move from (16,12) writes (16,12)←2 in CLR1.
- Wall: (16,12)=WALL, `next1`=(16,12). Expect `blocked`=01, (16,13)←5 in CAP1, `under1` stays EMPTY.
- Off-board: `next2`=(40,13). Expect `blocked[1]`=1, GHOST2 rewritten at `c2`; no write at x=40.
- Pacman hit: (24,13)=PACMAN, `next2`=(24,13). Expect `ghost_hit`=10, write 6 at (24,13), `under2`=EMPTY; flags clear on next `start`.
- Stacking/swap: n2 == n1 = (20,13) over PILL. Expect `under2`=2 and (20,13)←6 last. Then with c1=(23,13), c2=(16,13) (swap), expect correct restores with no residual ghost codes.
- Protocol: `start` at cycles 3 and 5 ignored; reset asserted in CAP1 → IDLE next cycle, `wr_en=0`, `wrdone` never pulses.
